// File: rtl/pipe_commit_tracker_if.sv
// Handshake bundle between a tracked pipeline's taps and pipe_commit_tracker.
// flush_i exists only when PIPE_TRACK_FLUSH_EN is defined.
interface pipe_commit_tracker_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 8
);
  logic                  issue_i;
  logic                  s1_valid_i;
  logic [NUM_STAGES-1:0] stall_i;
`ifdef PIPE_TRACK_FLUSH_EN
  logic                  flush_i;
`endif
  logic                  start_o;
  logic                  started_o;
  logic [NUM_STAGES-1:0] token_o;
  logic                  commit_o;
  logic                  iend_o;
  logic                  ended_o;
  logic                  timeout_o;
  logic [CNT_W-1:0]      cycle_cnt_o;

  modport master (
`ifdef PIPE_TRACK_FLUSH_EN
    output flush_i,
`endif
    output issue_i, s1_valid_i, stall_i,
    input  start_o, started_o, token_o, commit_o, iend_o, ended_o, timeout_o, cycle_cnt_o
  );

  modport slave (
`ifdef PIPE_TRACK_FLUSH_EN
    input  flush_i,
`endif
    input  issue_i, s1_valid_i, stall_i,
    output start_o, started_o, token_o, commit_o, iend_o, ended_o, timeout_o, cycle_cnt_o
  );
endinterface

// File: rtl/pipe_commit_tracker.sv
// Follows one issued token through NUM_STAGES stall-able stages; flags commit, in-bound end, timeout.
// PIPE_TRACK_FLUSH_EN adds a flush input that drops the token and any pending commit.
module pipe_commit_tracker #(
  parameter int NUM_STAGES = 4,
  parameter bit GATE_S1    = 1'b1,
  parameter int MAX_CYCLES = 50,
  parameter int CNT_SAT    = 132,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  pipe_commit_tracker_if.slave bus
);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(CNT_SAT);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CYCLES);

  logic                  start_q, started_q, commit_q, ended_q, timeout_q;
  logic [CNT_W-1:0]      cnt_q, cnt_nxt;
  logic [NUM_STAGES:2]   tok_q;
  logic [NUM_STAGES:1]   nxt;
  logic                  flush, inj, active, iend;

`ifdef PIPE_TRACK_FLUSH_EN
  assign flush = bus.flush_i;
`else
  assign flush = 1'b0;
`endif

  assign active  = start_q | started_q;
  assign inj     = start_q & ~flush & (GATE_S1 ? (bus.s1_valid_i & ~bus.stall_i[0]) : 1'b1);
  assign cnt_nxt = (active && cnt_q < SAT) ? cnt_q + CNT_W'(1) : cnt_q;
  assign iend    = commit_q & started_q & ~ended_q & (cnt_q <= MAXC);

  // nxt[k] is the token leaving stage k this cycle.
  always_comb begin
    nxt    = '0;
    nxt[1] = inj;
    for (int k = 2; k <= NUM_STAGES; k++)
      nxt[k] = tok_q[k] & ~bus.stall_i[k-1] & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      started_q <= 1'b0;
      commit_q  <= 1'b0;
      ended_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      tok_q     <= '0;
    end else begin
      start_q   <= active ? 1'b0 : bus.issue_i;
      started_q <= active;
      cnt_q     <= cnt_nxt;
      commit_q  <= nxt[NUM_STAGES];
      ended_q   <= ended_q | iend;
      // Judged on the next count so timeout_o is already up when cnt shows MAX_CYCLES+1.
      timeout_q <= timeout_q | (active & ~ended_q & ~iend & (cnt_nxt > MAXC));
      if (flush) begin
        tok_q <= '0;
      end else begin
        for (int k = 2; k <= NUM_STAGES; k++)
          if (!bus.stall_i[k-1]) tok_q[k] <= nxt[k-1];
      end
    end
  end

  assign bus.start_o     = start_q;
  assign bus.started_o   = started_q;
  assign bus.token_o     = {tok_q, nxt[1]};
  assign bus.commit_o    = commit_q;
  assign bus.iend_o      = iend;
  assign bus.ended_o     = ended_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.cycle_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipe_commit_tracker.sv
// Bench for pipe_commit_tracker: directed scenarios plus randomized runs against a token-position model.
// Define PIPE_TRACK_FLUSH_EN for both RTL and bench to include the flush scenario.
module tb_pipe_commit_tracker;
  localparam int N    = 4;
  localparam int MAXC = 50;
  localparam int SAT  = 132;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_v = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_commit_tracker_if #(.NUM_STAGES(N), .CNT_W(CW)) bus ();

  pipe_commit_tracker #(
    .NUM_STAGES(N), .GATE_S1(1'b1), .MAX_CYCLES(MAXC), .CNT_SAT(SAT), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef PIPE_TRACK_FLUSH_EN
  assign bus.flush_i = flush_v;
`endif

  always #5 clk = ~clk;

  // Reference model: token position as a stage number (0 = no registered token).
  bit m_fired, m_start, m_started, m_commit, m_ended;
  int m_pos, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fired = 0; m_start = 0; m_started = 0; m_commit = 0; m_ended = 0;
      m_pos = 0; m_cnt = 0;
    end else begin
      bit inj, iend;
      int pos_n;
      inj   = m_start && bus.s1_valid_i && !bus.stall_i[0] && !flush_v;
      iend  = m_commit && m_started && !m_ended && (m_cnt <= MAXC);
      m_commit = (m_pos == N) && !bus.stall_i[N-1] && !flush_v;
      pos_n = m_pos;
      if (flush_v) pos_n = 0;
      else if (m_pos != 0) begin
        if (!bus.stall_i[m_pos-1]) begin
          if (m_pos == N) pos_n = 0;
          else if (bus.stall_i[m_pos]) pos_n = 0;
          else pos_n = m_pos + 1;
        end
      end else if (inj) pos_n = bus.stall_i[1] ? 0 : 2;
      m_pos = pos_n;
      if ((m_start || m_started) && m_cnt < SAT) m_cnt++;
      m_ended   = m_ended || iend;
      m_started = m_started || m_start;
      m_start   = !m_fired && bus.issue_i;
      if (m_start) m_fired = 1;
    end
  end

  function automatic logic [17:0] outs();
    return {bus.start_o, bus.started_o, bus.token_o, bus.commit_o, bus.iend_o,
            bus.ended_o, bus.timeout_o, bus.cycle_cnt_o};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.issue_i = 0; bus.s1_valid_i = 0; bus.stall_i = '0; flush_v = 0;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    bus.issue_i = 1; bus.s1_valid_i = 1; bus.stall_i = '0; flush_v = 0;
    rst_n = 0;
    next_cycle();
    checks++; if (bus.start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.start_o); end
    checks++; if (bus.started_o !== 1'b0) begin errors++; $display("FAIL reset_started: got %b expected 0", bus.started_o); end
    checks++; if (bus.token_o !== 4'b0000) begin errors++; $display("FAIL reset_token: got %b expected 0000", bus.token_o); end
    checks++; if (bus.commit_o !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b expected 0", bus.commit_o); end
    checks++; if (bus.iend_o !== 1'b0) begin errors++; $display("FAIL reset_iend: got %b expected 0", bus.iend_o); end
    checks++; if (bus.ended_o !== 1'b0) begin errors++; $display("FAIL reset_ended: got %b expected 0", bus.ended_o); end
    checks++; if (bus.timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout_o); end
    checks++; if (bus.cycle_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus.cycle_cnt_o); end
  endtask

  task automatic test_basic();
    do_reset();
    bus.issue_i = 1; bus.s1_valid_i = 1;
    for (int c = 0; c <= 6; c++) begin
      logic [N-1:0] et;
      et = '0;
      if (c >= 1 && c <= N) et[c-1] = 1'b1;
      @(negedge clk);
      checks++; if (bus.token_o !== et) begin errors++; $display("FAIL basic_token c%0d: got %b expected %b", c, bus.token_o, et); end
      checks++; if (bus.start_o !== (c == 1)) begin errors++; $display("FAIL basic_start c%0d: got %b expected %b", c, bus.start_o, c == 1); end
      checks++; if (bus.commit_o !== (c == 5)) begin errors++; $display("FAIL basic_commit c%0d: got %b expected %b", c, bus.commit_o, c == 5); end
      checks++; if (bus.iend_o !== (c == 5)) begin errors++; $display("FAIL basic_iend c%0d: got %b expected %b", c, bus.iend_o, c == 5); end
      checks++; if (bus.ended_o !== (c == 6)) begin errors++; $display("FAIL basic_ended c%0d: got %b expected %b", c, bus.ended_o, c == 6); end
      checks++; if (bus.cycle_cnt_o !== 8'((c > 0) ? c - 1 : 0)) begin errors++; $display("FAIL basic_cnt c%0d: got %0d expected %0d", c, bus.cycle_cnt_o, (c > 0) ? c - 1 : 0); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int tbl [0:9] = '{0, 1, 2, 4, 4, 4, 4, 8, 0, 0};
    do_reset();
    bus.issue_i = 1; bus.s1_valid_i = 1;
    for (int c = 0; c <= 9; c++) begin
      bus.stall_i = (c >= 3 && c <= 5) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      checks++; if (bus.token_o !== 4'(tbl[c])) begin errors++; $display("FAIL stall_token c%0d: got %b expected %b", c, bus.token_o, 4'(tbl[c])); end
      checks++; if (bus.commit_o !== (c == 8)) begin errors++; $display("FAIL stall_commit c%0d: got %b expected %b", c, bus.commit_o, c == 8); end
      if (c == 8) begin
        checks++; if (bus.cycle_cnt_o !== 8'd7) begin errors++; $display("FAIL stall_cnt: got %0d expected 7", bus.cycle_cnt_o); end
      end
      next_cycle();
    end
  endtask

  task automatic test_lost();
    bit any_tok = 0, any_commit = 0;
    int to_cnt = -1;
    do_reset();
    bus.issue_i = 1; bus.s1_valid_i = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      if (bus.token_o !== 4'b0000) any_tok = 1;
      if (bus.commit_o !== 1'b0) any_commit = 1;
      if (bus.timeout_o === 1'b1 && to_cnt < 0) to_cnt = int'(bus.cycle_cnt_o);
      next_cycle();
    end
    @(negedge clk);
    checks++; if (any_tok) begin errors++; $display("FAIL lost_token: got nonzero token expected 0000"); end
    checks++; if (any_commit) begin errors++; $display("FAIL lost_commit: got commit expected none"); end
    checks++; if (to_cnt != MAXC + 1) begin errors++; $display("FAIL lost_timeout_cnt: got %0d expected %0d", to_cnt, MAXC + 1); end
    checks++; if (bus.cycle_cnt_o !== 8'(SAT)) begin errors++; $display("FAIL lost_sat: got %0d expected %0d", bus.cycle_cnt_o, SAT); end
    checks++; if (bus.ended_o !== 1'b0) begin errors++; $display("FAIL lost_ended: got %b expected 0", bus.ended_o); end
  endtask

  task automatic test_bound(input int target);
    bit seen = 0, s_iend = 0, s_to = 0;
    int s_cnt = -1;
    do_reset();
    bus.issue_i = 1; bus.s1_valid_i = 1;
    for (int c = 0; c < 80; c++) begin
      bus.stall_i = (m_pos == N && m_cnt < target - 1) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (bus.commit_o === 1'b1 && !seen) begin
        seen = 1; s_cnt = int'(bus.cycle_cnt_o); s_iend = bus.iend_o; s_to = bus.timeout_o;
      end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (s_cnt != target) begin errors++; $display("FAIL bound%0d_commit_cnt: got %0d expected %0d", target, s_cnt, target); end
    checks++; if (s_iend != (target <= MAXC)) begin errors++; $display("FAIL bound%0d_iend: got %b expected %b", target, s_iend, target <= MAXC); end
    checks++; if (s_to != (target > MAXC)) begin errors++; $display("FAIL bound%0d_timeout_at_commit: got %b expected %b", target, s_to, target > MAXC); end
    checks++; if (bus.ended_o !== (target <= MAXC)) begin errors++; $display("FAIL bound%0d_ended: got %b expected %b", target, bus.ended_o, target <= MAXC); end
    checks++; if (bus.timeout_o !== (target > MAXC)) begin errors++; $display("FAIL bound%0d_timeout: got %b expected %b", target, bus.timeout_o, target > MAXC); end
  endtask

  task automatic test_midflight();
    do_reset();
    bus.issue_i = 1; bus.s1_valid_i = 1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++; if (bus.token_o !== 4'b0100) begin errors++; $display("FAIL mid_token_before: got %b expected 0100", bus.token_o); end
    #1 rst_n = 0;
    #1;
    checks++; if (outs() !== 18'd0) begin errors++; $display("FAIL mid_async_clear: got %h expected 0", outs()); end
    bus.issue_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++; if (bus.start_o !== 1'b0 || bus.cycle_cnt_o !== 8'd0) begin errors++; $display("FAIL mid_idle: got start %b cnt %0d expected 0 0", bus.start_o, bus.cycle_cnt_o); end
    next_cycle();
    bus.issue_i = 1;
    @(negedge clk);
    checks++; if (bus.start_o !== 1'b0) begin errors++; $display("FAIL mid_start_early: got %b expected 0", bus.start_o); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.start_o !== 1'b1 || bus.token_o !== 4'b0001) begin errors++; $display("FAIL mid_restart: got start %b token %b expected 1 0001", bus.start_o, bus.token_o); end
  endtask

`ifdef PIPE_TRACK_FLUSH_EN
  task automatic test_flush();
    bit any_commit = 0;
    int to_cnt = -1;
    do_reset();
    bus.issue_i = 1; bus.s1_valid_i = 1;
    repeat (2) next_cycle();
    flush_v = 1;
    @(negedge clk);
    checks++; if (bus.token_o !== 4'b0010) begin errors++; $display("FAIL flush_token_before: got %b expected 0010", bus.token_o); end
    next_cycle();
    flush_v = 0;
    @(negedge clk);
    checks++; if (bus.token_o !== 4'b0000) begin errors++; $display("FAIL flush_token_after: got %b expected 0000", bus.token_o); end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.commit_o !== 1'b0) any_commit = 1;
      if (bus.timeout_o === 1'b1 && to_cnt < 0) to_cnt = int'(bus.cycle_cnt_o);
      next_cycle();
    end
    checks++; if (any_commit) begin errors++; $display("FAIL flush_commit: got commit expected none"); end
    checks++; if (to_cnt != MAXC + 1) begin errors++; $display("FAIL flush_timeout_cnt: got %0d expected %0d", to_cnt, MAXC + 1); end
  endtask
`endif

  task automatic test_random();
    for (int run = 0; run < 24; run++) begin
      int sprob, len;
      do_reset();
      sprob = $urandom_range(0, 3);
      len   = 60 + $urandom_range(0, 40);
      for (int c = 0; c < len; c++) begin
        logic [N-1:0] et;
        logic [17:0]  exp_o;
        bit inj, iend_e, to_e;
        bus.issue_i    = ($urandom_range(0, 3) == 0);
        bus.s1_valid_i = ($urandom_range(0, 4) != 0);
        for (int b = 0; b < N; b++) bus.stall_i[b] = ($urandom_range(0, 15) < sprob);
`ifdef PIPE_TRACK_FLUSH_EN
        flush_v = ($urandom_range(0, 40) == 0);
`endif
        @(negedge clk);
        inj = m_start && bus.s1_valid_i && !bus.stall_i[0] && !flush_v;
        et = '0;
        if (m_pos != 0) et[m_pos-1] = 1'b1;
        if (inj) et[0] = 1'b1;
        iend_e = m_commit && m_started && !m_ended && (m_cnt <= MAXC);
        to_e   = (m_cnt > MAXC) && !m_ended;
        exp_o  = {m_start, m_started, et, m_commit, iend_e, m_ended, to_e, 8'(m_cnt)};
        checks++;
        if (outs() !== exp_o) begin
          errors++;
          $display("FAIL random run%0d c%0d: got %b expected %b", run, c, outs(), exp_o);
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.issue_i = 0; bus.s1_valid_i = 0; bus.stall_i = '0;
    test_reset();
    test_basic();
    test_stall();
    test_lost();
    test_bound(MAXC);
    test_bound(MAXC + 1);
    test_midflight();
`ifdef PIPE_TRACK_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
